// File: rtl/uart_tx.sv
// UART transmitter: start bit, NUM_DATA_BITS data bits LSB first, optional parity,
// NUM_STOP_BITS stop bits. Every output comes straight from a register.
module uart_tx #(
    parameter int SYS_FREQ_HZ   = 12_000_000,
    parameter int BAUD_RATE     = 115_200,
    parameter int NUM_DATA_BITS = 8,
    parameter int PARITY        = 0,
    parameter int NUM_STOP_BITS = 1
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     tx_start,
    input  logic [NUM_DATA_BITS-1:0] transmit_data,
    output logic                     write_ready,
    output logic                     write_done,
    output logic                     tx_out,
    output logic [2:0]               dbg_state_o
);

    localparam int CLKS_PER_BIT = SYS_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W        = $clog2(NUM_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(NUM_DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(NUM_STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                   state_q;
    logic [CNT_W-1:0]         baud_cnt_q;
    logic [BIT_W-1:0]         bit_cnt_q;
    logic                     stop_cnt_q;
    logic [NUM_DATA_BITS-1:0] shift_q;
    logic                     parity_q;
    logic                     tx_q;
    logic                     ready_q;
    logic                     done_q;
    logic                     bit_end;

    assign bit_end     = (baud_cnt_q == CNT_LAST);
    assign tx_out      = tx_q;
    assign write_ready = ready_q;
    assign write_done  = done_q;
    assign dbg_state_o = state_q;

    // Handshake: a request is taken at a rising edge where tx_start=1 and
    // write_ready=1; write_ready then stays low until the write_done cycle,
    // and tx_start seen while write_ready=0 is dropped, never queued.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE) begin
                baud_cnt_q <= bit_end ? '0 : baud_cnt_q + CNT_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (tx_start) begin
                        shift_q    <= transmit_data;
                        // Odd parity is the inverted XOR of the payload.
                        parity_q   <= (^transmit_data) ^ 1'(PARITY == 1);
                        baud_cnt_q <= '0;
                        tx_q       <= 1'b0;
                        ready_q    <= 1'b0;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        tx_q      <= shift_q[0];
                        bit_cnt_q <= '0;
                        state_q   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            stop_cnt_q <= 1'b0;
                            if (PARITY != 0) begin
                                tx_q    <= parity_q;
                                state_q <= S_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= S_STOP;
                            end
                        end else begin
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        tx_q       <= 1'b1;
                        stop_cnt_q <= 1'b0;
                        state_q    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (stop_cnt_q == STOP_LAST) begin
                            tx_q    <= 1'b1;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances cover no/even/odd parity with 12 data bits
// and two stop bits with 8 data bits; expected line levels come from a bit list.
module tb_uart_tx;

    localparam int CPB = 12_000_000 / 115_200;

    logic             clk;
    logic [3:0]       rst_v;
    logic [3:0]       start_v;
    logic [3:0][15:0] data_v;
    logic [3:0]       ready_v;
    logic [3:0]       done_v;
    logic [3:0]       line_v;
    logic [3:0][2:0]  dbg_v;

    int nb_a   [4] = '{12, 12, 12, 8};
    int par_a  [4] = '{0, 2, 1, 0};
    int stop_a [4] = '{1, 1, 1, 2};

    int          n_checks;
    int          n_fail;
    logic [0:0]  exp_q[$];
    logic [15:0] frame_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    uart_tx #(.NUM_DATA_BITS(12), .PARITY(0), .NUM_STOP_BITS(1)) u_none (
        .sys_clk(clk), .rst_n(rst_v[0]), .tx_start(start_v[0]), .transmit_data(data_v[0][11:0]),
        .write_ready(ready_v[0]), .write_done(done_v[0]), .tx_out(line_v[0]), .dbg_state_o(dbg_v[0]));
    uart_tx #(.NUM_DATA_BITS(12), .PARITY(2), .NUM_STOP_BITS(1)) u_even (
        .sys_clk(clk), .rst_n(rst_v[1]), .tx_start(start_v[1]), .transmit_data(data_v[1][11:0]),
        .write_ready(ready_v[1]), .write_done(done_v[1]), .tx_out(line_v[1]), .dbg_state_o(dbg_v[1]));
    uart_tx #(.NUM_DATA_BITS(12), .PARITY(1), .NUM_STOP_BITS(1)) u_odd (
        .sys_clk(clk), .rst_n(rst_v[2]), .tx_start(start_v[2]), .transmit_data(data_v[2][11:0]),
        .write_ready(ready_v[2]), .write_done(done_v[2]), .tx_out(line_v[2]), .dbg_state_o(dbg_v[2]));
    uart_tx #(.NUM_DATA_BITS(8), .PARITY(0), .NUM_STOP_BITS(2)) u_stop2 (
        .sys_clk(clk), .rst_n(rst_v[3]), .tx_start(start_v[3]), .transmit_data(data_v[3][7:0]),
        .write_ready(ready_v[3]), .write_done(done_v[3]), .tx_out(line_v[3]), .dbg_state_o(dbg_v[3]));

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: list of line levels, one entry per bit period.
    task automatic build_expected(input int k, input logic [15:0] d);
        int ones;
        exp_q.delete();
        exp_q.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < nb_a[k]; i++) begin
            exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par_a[k] == 2) exp_q.push_back(1'((ones % 2) == 1));
        if (par_a[k] == 1) exp_q.push_back(1'((ones % 2) == 0));
        for (int s = 0; s < stop_a[k]; s++) exp_q.push_back(1'b1);
    endtask

    function automatic logic [15:0] rand_data(input int k);
        return 16'($urandom & ((1 << nb_a[k]) - 1));
    endfunction

    // ---------------- driver + monitor ----------------
    // Sends every word in frame_q back to back on instance k. disturb_at /
    // rst_at are cycle offsets within each frame (-1 disables).
    task automatic run_frames(input int k, input int disturb_at, input int rst_at);
        logic [15:0] cur;
        int          f_len, bad_ready, bad_done, n_done, n_low;
        logic        first_s;
        bit          stable, more;
        logic [0:0]  e;
        @(negedge clk);
        check_eq($sformatf("u%0d_idle_ready", k), ready_v[k], 1);
        check_eq($sformatf("u%0d_idle_line", k), line_v[k], 1);
        cur        = frame_q.pop_front();
        data_v[k]  = cur;
        start_v[k] = 1'b1;
        more       = 1;
        while (more) begin
            build_expected(k, cur);
            f_len     = exp_q.size() * CPB;
            bad_ready = 0;
            bad_done  = 0;
            stable    = 1;
            first_s   = 1'b0;
            @(negedge clk);
            start_v[k] = 1'b0;
            check_eq($sformatf("u%0d_accept_lat", k), {ready_v[k], line_v[k]}, 2'b00);
            for (int c = 0; c < f_len; c++) begin
                if (c > 0) @(negedge clk);
                if (ready_v[k] !== 1'b0) bad_ready++;
                if (done_v[k] !== 1'b0) bad_done++;
                if (c % CPB == 0) begin
                    first_s = line_v[k];
                    stable  = 1;
                end else if (line_v[k] !== first_s) begin
                    stable = 0;
                end
                if (c % CPB == CPB - 1) begin
                    e = exp_q.pop_front();
                    check_eq($sformatf("u%0d_bit%0d", k, c / CPB),
                             stable ? {1'b0, first_s} : 2'd2, {1'b0, e});
                end
                if (c == 1) data_v[k] = 16'($urandom);
                if (c == disturb_at) begin
                    start_v[k] = 1'b1;
                    data_v[k]  = 16'($urandom);
                end else if (c == disturb_at + 1) begin
                    start_v[k] = 1'b0;
                end
                if (c == rst_at) begin
                    rst_v[k] = 1'b0;
                    @(negedge clk);
                    rst_v[k] = 1'b1;
                    check_eq($sformatf("u%0d_rst_line", k), line_v[k], 1);
                    check_eq($sformatf("u%0d_rst_ready", k), ready_v[k], 1);
                    check_eq($sformatf("u%0d_rst_done", k), done_v[k], 0);
                    n_done = 0;
                    n_low  = 0;
                    repeat (f_len) begin
                        @(negedge clk);
                        if (done_v[k] !== 1'b0) n_done++;
                        if (line_v[k] !== 1'b1) n_low++;
                    end
                    check_eq($sformatf("u%0d_rst_no_done", k), n_done, 0);
                    check_eq($sformatf("u%0d_rst_idle_line", k), n_low, 0);
                    exp_q.delete();
                    frame_q.delete();
                    return;
                end
            end
            check_eq($sformatf("u%0d_busy_ready", k), bad_ready, 0);
            check_eq($sformatf("u%0d_early_done", k), bad_done, 0);
            @(negedge clk);
            check_eq($sformatf("u%0d_done_pulse", k), done_v[k], 1);
            check_eq($sformatf("u%0d_done_ready", k), ready_v[k], 1);
            check_eq($sformatf("u%0d_done_line", k), line_v[k], 1);
            if (frame_q.size() > 0) begin
                cur        = frame_q.pop_front();
                data_v[k]  = cur;
                start_v[k] = 1'b1;
            end else begin
                more = 0;
                @(negedge clk);
                check_eq($sformatf("u%0d_done_width", k), done_v[k], 0);
                check_eq($sformatf("u%0d_post_line", k), line_v[k], 1);
                check_eq($sformatf("u%0d_post_ready", k), ready_v[k], 1);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_v    = 4'b0000;
        start_v  = 4'b1111;
        for (int k = 0; k < 4; k++) data_v[k] = 16'($urandom);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("u%0d_reset_line", k), line_v[k], 1);
            check_eq($sformatf("u%0d_reset_ready", k), ready_v[k], 1);
            check_eq($sformatf("u%0d_reset_done", k), done_v[k], 0);
        end
        rst_v   = 4'b1111;
        start_v = 4'b0000;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("u%0d_release_line", k), line_v[k], 1);
        end

        // Basic and random frames, no parity.
        frame_q.push_back(16'h04CA);
        run_frames(0, -1, -1);
        repeat (2) begin
            frame_q.push_back(rand_data(0));
            run_frames(0, -1, -1);
        end

        // Back-to-back: each next request is presented in the write_done cycle.
        frame_q.push_back(16'h095B);
        frame_q.push_back(16'h0D38);
        frame_q.push_back(rand_data(0));
        run_frames(0, -1, -1);

        // tx_start pulse and data change while busy.
        frame_q.push_back(rand_data(0));
        run_frames(0, $urandom_range(200, 900), -1);

        // Reset during a data bit, then a clean frame.
        frame_q.push_back(rand_data(0));
        run_frames(0, -1, 5 * CPB + $urandom_range(0, CPB - 1));
        frame_q.push_back(16'h00A5);
        run_frames(0, -1, -1);

        // Even and odd parity.
        for (int k = 1; k <= 2; k++) begin
            frame_q.push_back(16'h04CA);
            run_frames(k, -1, -1);
            repeat (2) begin
                frame_q.push_back(rand_data(k));
                run_frames(k, -1, -1);
            end
        end

        // Two stop bits.
        frame_q.push_back(16'h00A5);
        run_frames(3, -1, -1);
        frame_q.push_back(rand_data(3));
        frame_q.push_back(rand_data(3));
        run_frames(3, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
